cmplx_fxp_mult: RTL and testbench

Pipelined signed fixed-point complex multiplier, the parametrised successor to the team's scalar Q-format multiplier, for the radix-2 FFT butterfly twiddle path. Computes P = A * W on two's-complement Q-format operands, with selectable rounding, saturation and an overflow flag per sample. Uses a valid/ready handshake with a fixed 3-cycle latency and full-throughput backpressure. Replaces the earlier sign-magnitude scheme, which truncated toward zero and detected completion by output change.

---
 rtl/fft_fxp_pkg.sv | 29 ++
 rtl/fxp_round_sat.sv | 47 ++++
 rtl/cmplx_fxp_mult.sv | 143 ++++++++++++++
 tb/tb_cmplx_fxp_mult.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_fxp_pkg.sv
// fft_fxp_pkg
//    Shared constants for the fixed-point FFT datapath:
//    - default operand width and fractional bits
//    - rounding-mode selectors
//    - saturation limits.
//    sat_max()/sat_min() return the N-bit signed limits in a 66-bit container.
//    66 bits is wide enough for the range check at the largest legal N (2*32+2).
package fft_fxp_pkg;

   localparam int N_DEFAULT     = 16;
   localparam int Q_DEFAULT     = 8;

   localparam int ROUND_FLOOR   = 0;
   localparam int ROUND_HALF_UP = 1;

   localparam int SAT_CALC_W    = 66;

   function automatic logic signed [SAT_CALC_W-1:0] sat_max(input int n);
      return (66'sd1 <<< (n - 1)) - 66'sd1;
   endfunction

   function automatic logic signed [SAT_CALC_W-1:0] sat_min(input int n);
      return -(66'sd1 <<< (n - 1));
   endfunction

   localparam logic signed [SAT_CALC_W-1:0] SAT_MAX_DEFAULT = sat_max(N_DEFAULT);
   localparam logic signed [SAT_CALC_W-1:0] SAT_MIN_DEFAULT = sat_min(N_DEFAULT);

endpackage

// File: rtl/fxp_round_sat.sv
// fxp_round_sat
//    Combinational rounding and saturation of a (2N+1)-bit sum of Q-format
//    products.
//    The sum is first rounded, then shifted right arithmetically by Q.
//    The shifted value is then clamped to the N-bit signed range.
// Ports:
//    i_val  in  2N+1  signed full-precision sum
//    o_val  out N     rounded / saturated result
//    o_sat  out 1     result was clamped
module fxp_round_sat
   import fft_fxp_pkg::*;
#(
   parameter int N          = N_DEFAULT,
   parameter int Q          = Q_DEFAULT,
   parameter int ROUND_MODE = ROUND_FLOOR
) (
   input  logic signed [2*N:0] i_val,
   output logic [N-1:0]        o_val,
   output logic                o_sat
);

   // One guard bit above the input so the rounding constant can never wrap.
   localparam int W = 2*N + 2;

   localparam logic signed [W-1:0] MAX_V = W'(sat_max(N));
   localparam logic signed [W-1:0] MIN_V = W'(sat_min(N));
   localparam logic signed [W-1:0] RND_V = (ROUND_MODE == ROUND_HALF_UP) ?
                                           W'(66'sd1 <<< (Q - 1)) : W'(66'sd0);

   logic signed [W-1:0] biased;
   logic signed [W-1:0] shifted;

   always_comb begin
      biased  = $signed({i_val[2*N], i_val}) + RND_V;
      shifted = biased >>> Q;
      o_val   = shifted[N-1:0];
      o_sat   = 1'b0;
      if (shifted > MAX_V) begin
         o_val = MAX_V[N-1:0];
         o_sat = 1'b1;
      end else if (shifted < MIN_V) begin
         o_val = MIN_V[N-1:0];
         o_sat = 1'b1;
      end
   end

endmodule

// File: rtl/cmplx_fxp_mult.sv
// cmplx_fxp_mult
//    Pipelined signed Q-format complex multiplier P = A * W.
//    The latency is 3 enabled cycles.
//    Stage 1 registers the operands.
//    Stage 2 forms the four partial products.
//    Stage 3 sums, rounds and saturates the products into the output register.
//    Every stage advances together whenever the output register is empty or
//    is being drained (en = !o_valid || i_ready).
// Ports:
//    i_clk, i_rst            clock, synchronous active-high reset
//    i_valid / o_ready       input handshake
//    i_a_re, i_a_im          operand A (N-bit signed)
//    i_w_re, i_w_im          twiddle W (N-bit signed)
//    i_conj                  use conj(W) for this sample (only with CMPLX_MULT_CONJ_EN)
//    o_valid / i_ready       output handshake
//    o_p_re, o_p_im          result (N-bit signed)
//    o_ovf                   at least one component saturated
// Optional build macro: CMPLX_MULT_CONJ_EN adds i_conj.
module cmplx_fxp_mult
   import fft_fxp_pkg::*;
#(
   parameter int N          = N_DEFAULT,
   parameter int Q          = Q_DEFAULT,
   parameter int ROUND_MODE = ROUND_FLOOR
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_a_re,
   input  logic [N-1:0] i_a_im,
   input  logic [N-1:0] i_w_re,
   input  logic [N-1:0] i_w_im,
`ifdef CMPLX_MULT_CONJ_EN
   input  logic         i_conj,
`endif
   output logic         o_valid,
   input  logic         i_ready,
   output logic [N-1:0] o_p_re,
   output logic [N-1:0] o_p_im,
   output logic         o_ovf
);

   logic en;

   logic         v1_reg, v2_reg, v3_reg;
   logic [N-1:0] a_re1_reg, a_im1_reg, w_re1_reg, w_im1_reg;
   logic         conj1_reg;

   logic signed [2*N-1:0] rr2_reg, ii2_reg, ri2_reg, ir2_reg;
   logic signed [2*N-1:0] a_re_x, a_im_x, w_re_x, w_im_x, w_im_sx;

   logic signed [2*N:0] sum_c  [2];
   logic [N-1:0]        rs_val [2];
   logic                rs_sat [2];

   logic [N-1:0] p_re_reg, p_im_reg;
   logic         ovf_reg;

   assign en      = !v3_reg || i_ready;
   assign o_ready = en;
   assign o_valid = v3_reg;
   assign o_p_re  = p_re_reg;
   assign o_p_im  = p_im_reg;
   assign o_ovf   = ovf_reg;

`ifdef CMPLX_MULT_CONJ_EN
   logic conj_in;
   assign conj_in = i_conj;
`else
   logic conj_in;
   assign conj_in = 1'b0;
`endif

   // Valid bits: cleared on reset so in-flight samples vanish.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v1_reg <= 1'b0;
         v2_reg <= 1'b0;
         v3_reg <= 1'b0;
      end else if (en) begin
         v1_reg <= i_valid;
         v2_reg <= v1_reg;
         v3_reg <= v2_reg;
      end
   end

   // Operand and product registers: contents are don't-care while invalid.
   always_ff @(posedge i_clk) begin
      if (en) begin
         a_re1_reg <= i_a_re;
         a_im1_reg <= i_a_im;
         w_re1_reg <= i_w_re;
         w_im1_reg <= i_w_im;
         conj1_reg <= conj_in;
         rr2_reg   <= a_re_x * w_re_x;
         ii2_reg   <= a_im_x * w_im_x;
         ri2_reg   <= a_re_x * w_im_x;
         ir2_reg   <= a_im_x * w_re_x;
      end
   end

   // Operands are sign-extended to 2N bits before multiplying.
   // This makes negating -2^(N-1) exact: 2N bits is at least N+1.
   // Every true product, conjugated or not, fits in 2N signed bits.
   // The 2N-bit truncated product is therefore exact.
   always_comb begin
      a_re_x  = {{N{a_re1_reg[N-1]}}, a_re1_reg};
      a_im_x  = {{N{a_im1_reg[N-1]}}, a_im1_reg};
      w_re_x  = {{N{w_re1_reg[N-1]}}, w_re1_reg};
      w_im_sx = {{N{w_im1_reg[N-1]}}, w_im1_reg};
      w_im_x  = conj1_reg ? -w_im_sx : w_im_sx;
   end

   assign sum_c[0] = {rr2_reg[2*N-1], rr2_reg} - {ii2_reg[2*N-1], ii2_reg};
   assign sum_c[1] = {ri2_reg[2*N-1], ri2_reg} + {ir2_reg[2*N-1], ir2_reg};

   // Lane 0 is the real part, lane 1 the imaginary part.
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      fxp_round_sat #(
         .N          (N),
         .Q          (Q),
         .ROUND_MODE (ROUND_MODE)
      ) u_round_sat (
         .i_val (sum_c[gi]),
         .o_val (rs_val[gi]),
         .o_sat (rs_sat[gi])
      );
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         p_re_reg <= '0;
         p_im_reg <= '0;
         ovf_reg  <= 1'b0;
      end else if (en) begin
         p_re_reg <= rs_val[0];
         p_im_reg <= rs_val[1];
         ovf_reg  <= rs_sat[0] | rs_sat[1];
      end
   end

endmodule

// File: tb/tb_cmplx_fxp_mult.sv
// tb_cmplx_fxp_mult
//    Two instances are built, one with floor rounding and one with
//    round-half-up rounding.
//    Both instances see the same stimulus and the same backpressure.
//    Expected results come from an integer reference model and are queued
//    when a sample is accepted.
//    A monitor pops from the queue and compares whenever an output transfers.
module tb_cmplx_fxp_mult;

   localparam int N = 16;
   localparam int Q = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          iv;
   logic          ir;
   logic          conj;
   logic [N-1:0]  a_re, a_im, w_re, w_im;

   logic          ordy0, ordy1, ov0, ov1, ovf0, ovf1;
   logic [N-1:0]  p_re0, p_im0, p_re1, p_im1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [N-1:0] re0, im0, re1, im1;
      logic         ov0, ov1;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   cmplx_fxp_mult #(.N(N), .Q(Q), .ROUND_MODE(0)) u_dut_floor (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (iv),
      .o_ready (ordy0),
      .i_a_re  (a_re),
      .i_a_im  (a_im),
      .i_w_re  (w_re),
      .i_w_im  (w_im),
`ifdef CMPLX_MULT_CONJ_EN
      .i_conj  (conj),
`endif
      .o_valid (ov0),
      .i_ready (ir),
      .o_p_re  (p_re0),
      .o_p_im  (p_im0),
      .o_ovf   (ovf0)
   );

   cmplx_fxp_mult #(.N(N), .Q(Q), .ROUND_MODE(1)) u_dut_round (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (iv),
      .o_ready (ordy1),
      .i_a_re  (a_re),
      .i_a_im  (a_im),
      .i_w_re  (w_re),
      .i_w_im  (w_im),
`ifdef CMPLX_MULT_CONJ_EN
      .i_conj  (conj),
`endif
      .o_valid (ov1),
      .i_ready (ir),
      .o_p_re  (p_re1),
      .o_p_im  (p_im1),
      .o_ovf   (ovf1)
   );

   // Reference model: exact integer arithmetic, then the rounding and
   // clamping rules.
   function automatic longint round_shift(input longint v, input int rm);
      longint t;
      t = v + ((rm == 1) ? (longint'(1) <<< (Q - 1)) : 0);
      return t >>> Q;
   endfunction

   function automatic void clamp(input longint v, output logic [N-1:0] r, output bit s);
      longint hi, lo;
      hi = (longint'(1) <<< (N - 1)) - 1;
      lo = -(longint'(1) <<< (N - 1));
      s  = 1'b0;
      if (v > hi) begin
         v = hi;
         s = 1'b1;
      end else if (v < lo) begin
         v = lo;
         s = 1'b1;
      end
      r = N'(v);
   endfunction

   function automatic exp_t model(input logic [N-1:0] ar, ai, wr, wi, input bit cj);
      longint sar, sai, swr, swi, re, im;
      logic [N-1:0] r;
      bit s_re, s_im;
      exp_t e;
      sar = longint'($signed(ar));
      sai = longint'($signed(ai));
      swr = longint'($signed(wr));
      swi = longint'($signed(wi));
      if (cj) swi = -swi;
      re = sar * swr - sai * swi;
      im = sar * swi + sai * swr;
      clamp(round_shift(re, 0), r, s_re); e.re0 = r;
      clamp(round_shift(im, 0), r, s_im); e.im0 = r; e.ov0 = s_re | s_im;
      clamp(round_shift(re, 1), r, s_re); e.re1 = r;
      clamp(round_shift(im, 1), r, s_im); e.im1 = r; e.ov1 = s_re | s_im;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor and scoreboard. Samples are taken on the falling edge, where
   // inputs (driven just after the rising edge) and outputs are both stable.
   bit           prev_rst = 1'b1;
   bit           have_hold = 1'b0;
   logic [N-1:0] hold_re0, hold_im0, hold_re1, hold_im1;
   logic         hold_ov0, hold_ov1;
   int           txn = 0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_rst  = 1'b1;
         have_hold = 1'b0;
      end else begin
         if (prev_rst) begin
            chk("rst_o_valid", 64'(ov0), 64'(0));
            chk("rst_o_valid_rnd", 64'(ov1), 64'(0));
            chk("rst_p_re", 64'(p_re0), 64'(0));
            chk("rst_p_im", 64'(p_im0), 64'(0));
            chk("rst_ovf", 64'(ovf0), 64'(0));
            chk("rst_o_ready", 64'(ordy0), 64'(1));
         end
         prev_rst = 1'b0;
         chk("o_ready_rule", 64'(ordy0), 64'(!ov0 || ir));
         chk("valid_lockstep", 64'(ov1), 64'(ov0));
         if (have_hold) begin
            chk("hold_valid", 64'(ov0), 64'(1));
            chk("hold_p_re", 64'(p_re0), 64'(hold_re0));
            chk("hold_p_im", 64'(p_im0), 64'(hold_im0));
            chk("hold_ovf", 64'(ovf0), 64'(hold_ov0));
            chk("hold_p_re_rnd", 64'(p_re1), 64'(hold_re1));
            chk("hold_p_im_rnd", 64'(p_im1), 64'(hold_im1));
            chk("hold_ovf_rnd", 64'(ovf1), 64'(hold_ov1));
         end
         have_hold = ov0 && !ir;
         hold_re0 = p_re0; hold_im0 = p_im0; hold_ov0 = ovf0;
         hold_re1 = p_re1; hold_im1 = p_im1; hold_ov1 = ovf1;
         if (ov0 && ir) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 64'(1), 64'(0));
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("p_re_floor", 64'(p_re0), 64'(e.re0));
               chk("p_im_floor", 64'(p_im0), 64'(e.im0));
               chk("ovf_floor", 64'(ovf0), 64'(e.ov0));
               chk("p_re_round", 64'(p_re1), 64'(e.re1));
               chk("p_im_round", 64'(p_im1), 64'(e.im1));
               chk("ovf_round", 64'(ovf1), 64'(e.ov1));
               $display("txn %0d: floor re=%h im=%h ovf=%b | round re=%h im=%h ovf=%b",
                        txn, p_re0, p_im0, ovf0, p_re1, p_im1, ovf1);
               txn++;
            end
         end
         if (iv && ordy0) exp_q.push_back(model(a_re, a_im, w_re, w_im, conj));
      end
   end

   // Drive one sample and hold it until it is accepted. Returns just after
   // the accepting edge, so consecutive calls stream back-to-back.
   task automatic send(input logic [N-1:0] ar, ai, wr, wi, input bit cj);
      int n;
      a_re = ar; a_im = ai; w_re = wr; w_im = wi; conj = cj;
      iv = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (ordy0) break;
         n++;
         if (n > 50) begin
            chk("accept_timeout", 64'(0), 64'(1));
            break;
         end
      end
      @(posedge clk);
      #1;
      iv = 1'b0;
   endtask

   function automatic logic [N-1:0] rnd_op();
      case ($urandom_range(7))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         default: return N'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1'b1; iv = 1'b0; ir = 1'b1; conj = 1'b0;
      a_re = '0; a_im = '0; w_re = '0; w_im = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Basic products, rounding cases and saturation corners
      send(16'h0100, 16'h0100, 16'h0100, 16'h0000, 1'b0);
      send(16'hFF00, 16'h0000, 16'h0080, 16'h0000, 1'b0);
      send(16'h0000, 16'h0100, 16'h0000, 16'h0100, 1'b0);
      send(16'h0001, 16'h0000, 16'h0080, 16'h0000, 1'b0);
      send(16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 1'b0);
      send(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b0);
      send(16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0);
      send(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0);
      send(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
`ifdef CMPLX_MULT_CONJ_EN
      send(16'h0000, 16'h0100, 16'h0000, 16'h0100, 1'b1);
      send(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1);
`endif

      // Eight back-to-back samples with a 4-cycle output stall mid-stream
      fork
         begin
            for (int k = 0; k < 8; k++)
               send(N'($urandom), N'($urandom), N'($urandom), N'($urandom), 1'b0);
         end
         begin
            repeat (4) @(posedge clk);
            #1 ir = 1'b0;
            repeat (4) @(posedge clk);
            #1 ir = 1'b1;
         end
      join

      // Reset with three samples in flight
      send(16'h0100, 16'h0200, 16'h0300, 16'h0040, 1'b0);
      send(16'h1234, 16'h0567, 16'h0089, 16'h0ABC, 1'b0);
      send(16'h7000, 16'h9000, 16'h0100, 16'h0100, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      // Randomised operands, valid and backpressure
      for (int c = 0; c < 400; c++) begin
         a_re = rnd_op(); a_im = rnd_op(); w_re = rnd_op(); w_im = rnd_op();
`ifdef CMPLX_MULT_CONJ_EN
         conj = 1'($urandom);
`else
         conj = 1'b0;
`endif
         iv = ($urandom_range(2) != 0);
         ir = ($urandom_range(3) != 0);
         @(posedge clk);
         #1;
      end
      iv = 1'b0;
      ir = 1'b1;

      begin
         int n;
         n = 0;
         while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
         end
         #1;
         chk("drain_pending", 64'(exp_q.size()), 64'(0));
      end
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
